// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter and its trace checker:
// checker FSM states and the single next-count rule (up, down, wrap, reset).
package counter_pkg;

   typedef enum logic [1:0] {
      ST_UNSYNC  = 2'd0,
      ST_LOCKING = 2'd1,
      ST_ARMED   = 2'd2
   } chk_state_t;

   // Computed at 32 bits; callers truncate to their width, which gives wrap modulo 2^W.
   function automatic logic [31:0] next_count(input logic        rst,
                                              input logic        down,
                                              input logic [31:0] cur);
      logic [31:0] res;
      res = 32'd0;
      if (rst) begin
         res = 32'd0;
      end else if (down) begin
         res = cur - 32'd1;
      end else begin
         res = cur + 32'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/counter_predict.sv
// Combinational expected-count calculator: value the counter should show now,
// given the previous sample of its reset, direction and output.
module counter_predict
   import counter_pkg::*;
#(
   parameter int unsigned W = 10
) (
   input  logic         p_rst,
   input  logic         p_mode,
   input  logic [W-1:0] p_cnt,
   output logic [W-1:0] exp_cnt
);

   // Expected value from the package rule, truncated back to W bits.
   always_comb begin
      exp_cnt = W'(next_count(p_rst, p_mode, 32'(p_cnt)));
   end

endmodule

// File: rtl/counter_trace_checker.sv
// Passive checker for the W-bit up/down counter: locks onto the observed count
// sequence, then flags, counts and captures every mismatching step.
module counter_trace_checker
   import counter_pkg::*;
#(
   parameter int unsigned W        = 10,
   parameter int unsigned LOCK_CYC = 2,
   parameter int unsigned ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dut_rst,
   input  logic             mode,
   input  logic [W-1:0]     cnt,
   output logic             armed,
   output logic             err,
   output logic             err_sticky,
   output logic [ERR_W-1:0] err_cnt,
   output logic [W-1:0]     first_bad,
   output logic [W-1:0]     first_exp
);

   localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CYC);
   localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

   chk_state_t       state_r, state_n_s;
   logic [3:0]       lock_cnt_r, lock_cnt_n_s, lock_inc_s;
   logic             p_rst_r, p_mode_r;
   logic [W-1:0]     p_cnt_r;
   logic [W-1:0]     exp_s;
   logic             match_s;
   logic             armed_r, err_r, sticky_r;
   logic             err_n_s, sticky_n_s;
   logic [ERR_W-1:0] err_cnt_r, err_cnt_n_s;
   logic [W-1:0]     first_bad_r, first_bad_n_s, first_exp_r, first_exp_n_s;

   counter_predict #(.W(W)) u_predict (
      .p_rst   (p_rst_r),
      .p_mode  (p_mode_r),
      .p_cnt   (p_cnt_r),
      .exp_cnt (exp_s)
   );

   assign match_s    = (cnt == exp_s);
   assign lock_inc_s = lock_cnt_r + 4'd1;

   // Next-state and error bookkeeping; the expectation always resyncs to the observed count.
   always_comb begin
      state_n_s     = state_r;
      lock_cnt_n_s  = lock_cnt_r;
      err_n_s       = 1'b0;
      err_cnt_n_s   = err_cnt_r;
      sticky_n_s    = sticky_r;
      first_bad_n_s = first_bad_r;
      first_exp_n_s = first_exp_r;
      case (state_r)
         ST_UNSYNC: begin
            state_n_s    = ST_LOCKING;
            lock_cnt_n_s = 4'd0;
         end
         ST_LOCKING: begin
            if (match_s) begin
               lock_cnt_n_s = lock_inc_s;
               if (lock_inc_s >= LOCK_TGT) begin
                  state_n_s = ST_ARMED;
               end else begin
                  state_n_s = ST_LOCKING;
               end
            end else begin
               lock_cnt_n_s = 4'd0;
            end
         end
         ST_ARMED: begin
            if (!match_s) begin
               err_n_s = 1'b1;
               if (err_cnt_r != ERR_MAX) begin
                  err_cnt_n_s = err_cnt_r + ERR_W'(1'b1);
               end else begin
                  err_cnt_n_s = err_cnt_r;
               end
               if (!sticky_r) begin
                  first_bad_n_s = cnt;
                  first_exp_n_s = exp_s;
                  sticky_n_s    = 1'b1;
               end else begin
                  sticky_n_s    = sticky_r;
               end
            end else begin
               err_n_s = 1'b0;
            end
         end
         default: begin
            state_n_s    = ST_UNSYNC;
            lock_cnt_n_s = 4'd0;
         end
      endcase
   end

   // State, previous-sample and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_UNSYNC;
         lock_cnt_r  <= 4'd0;
         p_rst_r     <= 1'b0;
         p_mode_r    <= 1'b0;
         p_cnt_r     <= {W{1'b0}};
         armed_r     <= 1'b0;
         err_r       <= 1'b0;
         sticky_r    <= 1'b0;
         err_cnt_r   <= {ERR_W{1'b0}};
         first_bad_r <= {W{1'b0}};
         first_exp_r <= {W{1'b0}};
      end else begin
         state_r     <= state_n_s;
         lock_cnt_r  <= lock_cnt_n_s;
         p_rst_r     <= dut_rst;
         p_mode_r    <= mode;
         p_cnt_r     <= cnt;
         armed_r     <= (state_n_s == ST_ARMED);
         err_r       <= err_n_s;
         sticky_r    <= sticky_n_s;
         err_cnt_r   <= err_cnt_n_s;
         first_bad_r <= first_bad_n_s;
         first_exp_r <= first_exp_n_s;
      end
   end

   assign armed      = armed_r;
   assign err        = err_r;
   assign err_sticky = sticky_r;
   assign err_cnt    = err_cnt_r;
   assign first_bad  = first_bad_r;
   assign first_exp  = first_exp_r;

endmodule
